adc_spi_seq: RTL and testbench

Parametrised multi-channel SPI ADC sequencer for the printhead thermal loop. It round-robins the ADC mux (`adc_chsel`) over `NUM_CH` channels and clocks out one conversion per channel. Each result is latched into a per-channel register and compared against a per-channel setpoint to drive the `below` flags. It supersedes the fixed two-channel (die plus heatsink) SPI reader and sits between the ADC pins and the heater control logic.

---
 rtl/adc_spi_seq.sv | 176 +++++++++++++++++
 tb/tb_adc_spi_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_seq.sv
// Multi-channel SPI ADC sequencer: round-robins the mux, shifts one frame per channel,
// latches results and setpoint compares. Optional hysteresis via `ADC_SPI_SEQ_HYST_EN.
module adc_spi_seq #(
    parameter int NUM_CH     = 2,
    parameter int ADC_BITS   = 16,
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 12,
    parameter int CS_SETUP   = 4,
    parameter int CS_IDLE    = 24,
`ifdef ADC_SPI_SEQ_HYST_EN
    parameter int HYST       = 16,
`endif
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk48mhz,
    input  logic                         rstn,
    input  logic                         enable,
    output logic                         adc_clk,
    input  logic                         adc_dout,
    output logic [CH_W-1:0]              adc_chsel,
    output logic                         adc_cs,
    input  logic [NUM_CH*ADC_BITS-1:0]   adc_setpoint,
    output logic [NUM_CH*ADC_BITS-1:0]   adc_value,
    output logic                         adc_valid,
    output logic [CH_W-1:0]              adc_valid_ch,
    output logic [NUM_CH-1:0]            below
);

    // state    | meaning
    // IDLE     | cs high, sclk low, waiting for enable
    // SETUP    | cs low, CS_SETUP cycles before first sclk rise
    // SHIFT    | FRAME_BITS sclk periods, sample on each rise
    // CAPTURE  | write result, compare, pulse valid, raise cs
    // QUIET    | cs high for CS_IDLE cycles, mux advanced
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_CAPTURE,
        ST_QUIET
    } state_t;

    localparam int CNT_MAX_A = (CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE;
    localparam int CNT_MAX   = (CNT_MAX_A > CLK_DIV) ? CNT_MAX_A : CLK_DIV;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int TOG_W     = $clog2(2 * FRAME_BITS);

    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] IDLE_LD   = CNT_W'(CS_IDLE - 1);
    localparam logic [CNT_W-1:0] DIV_LD    = CNT_W'(CLK_DIV - 1);
    localparam logic [TOG_W-1:0] TOG_LD    = TOG_W'(2 * FRAME_BITS - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [TOG_W-1:0]        tog_left;
    logic [FRAME_BITS-1:0]   shreg;
    logic [CH_W-1:0]         ch;
    logic [CH_W-1:0]         ch_next;
    logic [ADC_BITS-1:0]     result;
    logic [ADC_BITS-1:0]     setpoint;
    logic                    cap_below;

    assign adc_chsel = ch;
    assign ch_next   = (ch == LAST_CH) ? '0 : ch + 1'b1;
    assign result    = shreg[ADC_BITS-1:0];
    assign setpoint  = adc_setpoint[ch*ADC_BITS +: ADC_BITS];

    always_comb begin
        cap_below = below[ch];
`ifdef ADC_SPI_SEQ_HYST_EN
        // Clear threshold widened by one bit so setpoint + HYST never wraps.
        if (result < setpoint) begin
            cap_below = 1'b1;
        end else if ({1'b0, result} >= ({1'b0, setpoint} + (ADC_BITS+1)'(HYST))) begin
            cap_below = 1'b0;
        end
`else
        cap_below = (result < setpoint);
`endif
    end

    always_ff @(posedge clk48mhz or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            tog_left     <= '0;
            shreg        <= '0;
            ch           <= '0;
            adc_cs       <= 1'b1;
            adc_clk      <= 1'b0;
            adc_value    <= '0;
            below        <= '0;
            adc_valid    <= 1'b0;
            adc_valid_ch <= '0;
        end else begin
            adc_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    adc_cs  <= 1'b1;
                    adc_clk <= 1'b0;
                    if (enable) begin
                        state  <= ST_SETUP;
                        adc_cs <= 1'b0;
                        cnt    <= SETUP_LD;
                    end
                end

                ST_SETUP: begin
                    if (cnt == '0) begin
                        state    <= ST_SHIFT;
                        adc_clk  <= 1'b1;
                        shreg    <= FRAME_BITS'({shreg, adc_dout});
                        cnt      <= DIV_LD;
                        tog_left <= TOG_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // tog_left reaching zero marks the last fall; one more half period
                // completes the final sclk period before capture.
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        cnt <= DIV_LD;
                        if (tog_left == '0) begin
                            state <= ST_CAPTURE;
                        end else begin
                            tog_left <= tog_left - 1'b1;
                            adc_clk  <= ~adc_clk;
                            if (!adc_clk) begin
                                shreg <= FRAME_BITS'({shreg, adc_dout});
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    adc_cs       <= 1'b1;
                    adc_valid    <= 1'b1;
                    adc_valid_ch <= ch;
                    adc_value[ch*ADC_BITS +: ADC_BITS] <= result;
                    below[ch]    <= cap_below;
                    cnt          <= IDLE_LD;
                    state        <= ST_QUIET;
                end

                ST_QUIET: begin
                    if (cnt == IDLE_LD) begin
                        ch <= ch_next;
                    end
                    if (cnt == '0) begin
                        if (enable) begin
                            state  <= ST_SETUP;
                            adc_cs <= 1'b0;
                            cnt    <= SETUP_LD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    adc_cs  <= 1'b1;
                    adc_clk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_seq.sv
// Scoreboard bench for adc_spi_seq: an ADC model queues the expected result at each
// cs fall, and every adc_valid pulse is checked against the head of that queue.
module tb_adc_spi_seq;

    localparam int NUM_CH    = 4;
    localparam int ADC_BITS  = 16;
    localparam int FRAME_LEN = 4 + 2 * 12 * 16 + 1;
    localparam int HYST      = 16;

    logic                        clk48mhz = 1'b0;
    logic                        rstn     = 1'b0;
    logic                        enable   = 1'b0;
    logic                        adc_clk;
    logic                        adc_dout = 1'b0;
    logic [1:0]                  adc_chsel;
    logic                        adc_cs;
    logic [NUM_CH*ADC_BITS-1:0]  adc_setpoint = {16'h0400, 16'h0350, 16'h0150, 16'h1000};
    logic [NUM_CH*ADC_BITS-1:0]  adc_value;
    logic                        adc_valid;
    logic [1:0]                  adc_valid_ch;
    logic [NUM_CH-1:0]           below;

    adc_spi_seq #(.NUM_CH(NUM_CH)) dut (
        .clk48mhz     (clk48mhz),
        .rstn         (rstn),
        .enable       (enable),
        .adc_clk      (adc_clk),
        .adc_dout     (adc_dout),
        .adc_chsel    (adc_chsel),
        .adc_cs       (adc_cs),
        .adc_setpoint (adc_setpoint),
        .adc_value    (adc_value),
        .adc_valid    (adc_valid),
        .adc_valid_ch (adc_valid_ch),
        .below        (below)
    );

    always #10 clk48mhz = ~clk48mhz;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] val;
        logic        blw;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_valid = 0;
    int          n_rise = 0;
    int          lowcnt = 0;
    int          lap[NUM_CH];
    logic [1:0]  exp_ch = '0;
    logic [3:0]  exp_below = '0;
    logic [15:0] exp_last[NUM_CH];
    logic [15:0] sreg = '0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_valid = 1'b0;
    logic [1:0]  prev_chsel = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] resp(input int c, input int l);
        if (c == 0) begin
            case (l)
                0:       return 16'h1234;
                1:       return 16'h0FFF;
                default: return 16'h1000;
            endcase
        end
        return 16'((c + 1) * 256);
    endfunction

    function automatic logic model_below(input logic prev, input logic [15:0] v, input logic [15:0] sp);
`ifdef ADC_SPI_SEQ_HYST_EN
        if (v < sp) return 1'b1;
        if ({1'b0, v} >= ({1'b0, sp} + 17'(HYST))) return 1'b0;
        return prev;
`else
        return v < sp;
`endif
    endfunction

    always @(negedge adc_clk) begin
        sreg     = sreg << 1;
        adc_dout = sreg[15];
    end

    always @(negedge clk48mhz) begin
        if (!rstn) begin
            lowcnt    = 0;
            exp_ch    = '0;
            exp_below = '0;
            sb.delete();
            for (int c = 0; c < NUM_CH; c++) begin
                lap[c]      = 0;
                exp_last[c] = '0;
            end
        end else begin
            if (prev_cs && !adc_cs) begin
                exp_t e;
                check("chsel_seq", adc_chsel, exp_ch);
                e.ch  = adc_chsel;
                e.val = resp(adc_chsel, lap[adc_chsel]);
                e.blw = model_below(exp_below[adc_chsel], e.val, adc_setpoint[adc_chsel*16 +: 16]);
                exp_below[adc_chsel] = e.blw;
                lap[adc_chsel]++;
                sb.push_back(e);
                sreg     = e.val;
                adc_dout = e.val[15];
                exp_ch   = exp_ch + 2'd1;
            end
            if (!adc_cs) begin
                lowcnt++;
            end else if (lowcnt != 0) begin
                check("cs_low_len", lowcnt, FRAME_LEN);
                lowcnt = 0;
            end
            if (adc_chsel != prev_chsel) check("chsel_chg_cs_high", adc_cs, 1);
            if (adc_clk && !prev_sclk) n_rise++;
            if (adc_valid) begin
                n_valid++;
                check("valid_width", {prev_valid, adc_valid}, 2'b01);
                check("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("valid_ch", adc_valid_ch, e.ch);
                    check("value", adc_value[e.ch*16 +: 16], e.val);
                    check("below", below[e.ch], e.blw);
                    exp_last[e.ch] = e.val;
                end
            end
        end
        prev_cs    = adc_cs;
        prev_sclk  = adc_clk;
        prev_valid = adc_valid;
        prev_chsel = adc_chsel;
    end

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_cs"}, adc_cs, 1);
        check({pfx, "_sclk"}, adc_clk, 0);
        check({pfx, "_chsel"}, adc_chsel, 0);
        check({pfx, "_valid"}, adc_valid, 0);
        check({pfx, "_valid_ch"}, adc_valid_ch, 0);
        check({pfx, "_value"}, (adc_value == '0), 1);
        check({pfx, "_below"}, below, 0);
    endtask

    task automatic wait_valids(input int target, input int budget, input string tag);
        int k = 0;
        while (n_valid < target && k < budget) begin
            @(negedge clk48mhz);
            k++;
        end
        check(tag, n_valid >= target, 1);
    endtask

    initial begin
        int v0;
        int r0;
        int k;
        #25;
        check_reset_vals("por");
        @(negedge clk48mhz);
        rstn = 1'b1;
        repeat (3) @(negedge clk48mhz);
        check("idle_cs", adc_cs, 1);
        check("idle_no_sclk", n_rise, 0);

        enable = 1'b1;
        @(negedge clk48mhz);
        check("cs_fall_after_en", adc_cs, 0);
        repeat (60) @(negedge clk48mhz);
        check("sclk_running", n_rise > 0, 1);

        // Reset mid-SHIFT, between clock edges.
        #3 rstn = 1'b0;
        #1 check_reset_vals("rst_mid");
        @(negedge clk48mhz);
        @(negedge clk48mhz);
        rstn = 1'b1;
        @(negedge clk48mhz);
        check("cs_fall_after_rst", adc_cs, 0);

        // Ten frames: round robin over all channels, ch0 sees 0x1234, 0x0FFF, 0x1000.
        wait_valids(10, 10 * 413 + 500, "frames_done");
        for (int c = 0; c < NUM_CH; c++) begin
            check("slice_hold", adc_value[c*16 +: 16], exp_last[c]);
        end
        check("ch0_final", adc_value[15:0], 16'h1000);
`ifdef ADC_SPI_SEQ_HYST_EN
        check("below_vec", below, 4'b0101);
`else
        check("below_vec", below, 4'b0100);
`endif

        // Drop enable in the middle of the next frame.
        k = 0;
        while (adc_cs && k < 500) begin
            @(negedge clk48mhz);
            k++;
        end
        check("drop_cs_fell", adc_cs, 0);
        repeat (60) @(negedge clk48mhz);
        v0 = n_valid;
        enable = 1'b0;
        wait_valids(v0 + 1, 500, "drop_frame_done");
        r0 = n_rise;
        repeat (300) @(negedge clk48mhz);
        check("drop_one_valid", n_valid, v0 + 1);
        check("drop_no_sclk", n_rise, r0);
        check("drop_cs_high", adc_cs, 1);
        check("drop_sclk_low", adc_clk, 0);
        check("drop_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
